dm_sized: RTL



---
 rtl/dm_sized.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/dm_sized.sv
// Byte-addressed single-port data memory for the MIPS-lite datapath.
// Sized loads/stores, misalignment flagging, fixed-latency responses and an optional clear sweep.
module dm_sized #(
  parameter int WORDS          = 256,
  parameter int LATENCY        = 1,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int AW            = $clog2(WORDS) + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          write_enable,
  input  logic [AW-1:0] addr,
  input  logic [1:0]    size,
  input  logic          sign_ext,
  input  logic [31:0]   data_in,
  output logic          resp_valid,
  output logic [31:0]   data_out,
  output logic          misaligned
);

  localparam int IW = AW - 2;
  // The raw pipeline needs LATENCY-1 stages; keep at least one so the array is never empty.
  localparam int PD   = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam int TAIL = (LATENCY > 1) ? LATENCY - 2 : 0;

  typedef enum logic {S_CLEAR, S_IDLE} state_e;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_e;

  // Everything a response needs; extraction happens just before the output register.
  typedef struct packed {
    logic        valid;
    logic        is_store;
    logic        mis;
    logic [1:0]  lane;
    size_e       sz;
    logic        sext;
    logic [31:0] word;
  } slot_t;

  localparam state_e RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          clear_we;

  logic          accept;
  logic [IW-1:0] widx;
  size_e         req_sz;
  logic          req_mis;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   rd_word;
  slot_t         req_slot;
  slot_t         tail;
  slot_t         pipe_q [PD];

  logic [31:0]   mem [WORDS];

  // ---------------------------------------------------------------------------
  // Control FSM: clear sweep after reset, then idle accepting requests.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    clear_we  = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clear_we = !rst;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == IW'(WORDS - 1)) state_d = S_IDLE;
      end
      S_IDLE:  req_ready = !rst;
      default: state_d = RESET_STATE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign accept = req_valid && req_ready;
  assign widx   = addr[AW-1:2];
  assign req_sz = size_e'(size);

  always_comb begin
    req_mis = 1'b0;
    be      = 4'b0000;
    wdata   = data_in;
    case (req_sz)
      SZ_BYTE: begin
        be    = 4'b0001 << addr[1:0];
        wdata = {4{data_in[7:0]}};
      end
      SZ_HALF: begin
        req_mis = addr[0];
        be      = addr[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{data_in[15:0]}};
      end
      SZ_WORD: begin
        req_mis = (addr[1:0] != 2'b00);
        be      = 4'b1111;
      end
      default: req_mis = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage: one write per cycle, either the clear sweep or a store.
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch; zeroing is the FSM sweep, so with
  // CLEAR_ON_RESET=0 contents (including stores already accepted) survive rst.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[cnt_q] <= '0;
    end else if (accept && write_enable && !req_mis) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Reading the array after the previous edge gives store-then-load forwarding for free.
  assign rd_word = mem[widx];

  always_comb begin
    req_slot          = '0;
    req_slot.valid    = accept;
    req_slot.is_store = write_enable;
    req_slot.mis      = req_mis;
    req_slot.lane     = addr[1:0];
    req_slot.sz       = req_sz;
    req_slot.sext     = sign_ext;
    req_slot.word     = rd_word;
  end

  // ---------------------------------------------------------------------------
  // Response pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PD; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= req_slot;
      for (int i = 1; i < PD; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail = (LATENCY > 1) ? pipe_q[TAIL] : req_slot;

  function automatic logic [31:0] extract(input slot_t s);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = s.word[8*s.lane +: 8];
    h = s.lane[1] ? s.word[31:16] : s.word[15:0];
    r = '0;
    if (s.valid && !s.mis && !s.is_store) begin
      case (s.sz)
        SZ_BYTE: r = s.sext ? {{24{b[7]}}, b} : {24'h0, b};
        SZ_HALF: r = s.sext ? {{16{h[15]}}, h} : {16'h0, h};
        SZ_WORD: r = s.word;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      misaligned <= 1'b0;
      data_out   <= '0;
    end else begin
      resp_valid <= tail.valid;
      misaligned <= tail.valid && tail.mis;
      data_out   <= extract(tail);
    end
  end

endmodule
